zxw_mem_seq_ctrl_v: RTL

//  Sequencer for the 8-bit-counter / ROM / RAM / nibble-register memory datapath.
//  - Drives all datapath enables from one Moore FSM.
//  - COPY op: transfers a block of ROM nibbles into RAM via the M register.
//  - READ op: loads two consecutive RAM nibbles into the H and L output registers.
//  - Sits between the top-level switch/key logic and the datapath; that datapath's ROM/RAM clock on ~Clock.

---
 rtl/zxw_mem_seq_ctrl_v.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/zxw_mem_seq_ctrl_v.sv
// ---------------------------------------------------------------------------
// zxw_mem_seq_ctrl_v
//   Moore-FSM sequencer for the counter / ROM / RAM / nibble-register memory
//   datapath. It drives every datapath enable from the state register alone.
//     COPY (op=0): moves `length` ROM nibbles into RAM through the M register,
//                  two cycles per word (FETCH then WRITE).
//     READ (op=1): loads RAM[start_addr] into H and RAM[start_addr+1] into L.
//   The datapath's ROM/RAM operate on the falling edge, so a FETCH or WRITE
//   completes its memory access mid-cycle, before the counter moves.
//
// Optional feature macro: ZXW_MEM_SEQ_ABORT_EN
//   When defined, adds an `abort` input. abort in any busy state other than
//   DONE returns to IDLE on the next edge, clears the latched fields and
//   suppresses the done pulse.
//
// Ports
//   Clock        in   1       system clock, FSM on rising edge
//   Resetn       in   1       asynchronous active-low reset
//   start        in   1       operation request, honoured only in IDLE
//   op           in   1       0 = COPY, 1 = READ
//   start_addr   in   ADDR_W  first address of the operation
//   length       in   LEN_W   COPY word count (ignored for READ)
//   abort        in   1       (ZXW_MEM_SEQ_ABORT_EN only) cancel current op
//   Din_upcnt    out  ADDR_W  counter load value (start_addr latched at accept)
//   LD_EN_upcnt  out  1       counter parallel-load enable
//   Cnt_EN       out  1       counter increment enable
//   LD_EN_M      out  1       M register load (ROM -> M)
//   WR_EN        out  1       RAM write enable (M -> RAM[A])
//   LD_EN_H      out  1       H register load
//   LD_EN_L      out  1       L register load
//   busy         out  1       high in every state except IDLE
//   done         out  1       one-cycle pulse when an op completes
// ---------------------------------------------------------------------------
module zxw_mem_seq_ctrl_v #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
`ifdef ZXW_MEM_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic [ADDR_W-1:0] Din_upcnt,
    output logic              LD_EN_upcnt,
    output logic              Cnt_EN,
    output logic              LD_EN_M,
    output logic              WR_EN,
    output logic              LD_EN_H,
    output logic              LD_EN_L,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_WRITE = 3'd3,
        S_RD_H  = 3'd4,
        S_RD_L  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic               op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   rem_q;      // COPY words still to be written
    logic               abort_hit;

`ifdef ZXW_MEM_SEQ_ABORT_EN
    // DONE is excluded so a completing op always delivers its done pulse.
    assign abort_hit = abort && (state_q inside {S_LOAD, S_FETCH, S_WRITE, S_RD_H, S_RD_L});
`else
    assign abort_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request fields. They change only on accept in IDLE, so a start
    // pulsed while busy cannot disturb the operation in flight.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            op_q   <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
            rem_q  <= '0;
        end else if (abort_hit) begin
            op_q   <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
            rem_q  <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                op_q   <= op;
                addr_q <= start_addr;
                len_q  <= length;
            end
            if (state_q == S_LOAD) begin
                rem_q <= len_q;
            end else if (state_q == S_WRITE) begin
                rem_q <= rem_q - LEN_W'(1);
            end
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD: begin
                if (op_q)                state_d = S_RD_H;
                else if (len_q == '0)    state_d = S_DONE;
                else                     state_d = S_FETCH;
            end
            S_FETCH: state_d = S_WRITE;
            // rem_q still holds the pre-decrement count during WRITE.
            S_WRITE: state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_FETCH;
            S_RD_H:  state_d = S_RD_L;
            S_RD_L:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;   // unused encoding recovers to IDLE
        endcase
        if (abort_hit) state_d = S_IDLE;
    end

    // Moore output decode: depends on the state register only.
    always_comb begin
        LD_EN_upcnt = 1'b0;
        Cnt_EN      = 1'b0;
        LD_EN_M     = 1'b0;
        WR_EN       = 1'b0;
        LD_EN_H     = 1'b0;
        LD_EN_L     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_LOAD:  begin busy = 1'b1; LD_EN_upcnt = 1'b1; end
            S_FETCH: begin busy = 1'b1; LD_EN_M = 1'b1; end
            S_WRITE: begin busy = 1'b1; WR_EN = 1'b1; Cnt_EN = 1'b1; end
            S_RD_H:  begin busy = 1'b1; LD_EN_H = 1'b1; Cnt_EN = 1'b1; end
            S_RD_L:  begin busy = 1'b1; LD_EN_L = 1'b1; end
            S_DONE:  begin busy = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    assign Din_upcnt = addr_q;

endmodule
